// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// State encoding, latency limits and the latency-counter width.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    STEP,
    DONE
  } state_e;

  localparam int MEM_LAT_MAX = 3;
  localparam int LAT_CNT_W   = $clog2(MEM_LAT_MAX + 1);

  // Value loaded in READ so that the counter reaches zero on the cycle ROM data is valid.
  function automatic logic [LAT_CNT_W-1:0] lat_load_val(input int mem_lat);
    return LAT_CNT_W'(mem_lat - 1);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the PC counter, the program ROM and decode.
// master = the fetch sequencer, slave = its environment.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_incr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr_data;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    input  pc_addr, mem_rdata, instr_ready,
    output pc_incr, mem_addr, mem_rd_en, instr_data, instr_valid
  );

  modport slave (
    output pc_addr, mem_rdata, instr_ready,
    input  pc_incr, mem_addr, mem_rd_en, instr_data, instr_valid
  );
endinterface

// File: rtl/pc_fetch_lat_cnt.sv
// Loadable down-counter timing the ROM read latency; zero_o flags the data-valid cycle.
module pc_fetch_lat_cnt
  import pc_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [LAT_CNT_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o
);

  logic [LAT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: reads ROM at the PC, presents words downstream, pulses pc_incr.
// Optional FETCH_WRAP_STOP_EN: stop in DONE after the word at the top address.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  output logic            busy_o,
  output logic            seq_err_o,
  pc_fetch_ctrl_if.master bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load_val(MEM_LAT);

  state_e            state_q;
  logic [ADDR_W-1:0] shadow_q;
  logic [ADDR_W-1:0] shadow_next;
  logic              after_step_q;
  logic              pc_incr_q;
  logic              rd_en_q;
  logic [DATA_W-1:0] instr_data_q;
  logic              instr_valid_q;
  logic              busy_q;
  logic              seq_err_q;
  logic              lat_zero;

  assign shadow_next = shadow_q + 1'b1;

  pc_fetch_lat_cnt u_lat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == READ),
    .load_val_i (LAT_LOAD),
    .dec_i      (state_q == WAIT),
    .zero_o     (lat_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      after_step_q  <= 1'b0;
      pc_incr_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      instr_data_q  <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      pc_incr_q <= 1'b0;
      rd_en_q   <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q      <= READ;
            rd_en_q      <= 1'b1;
            busy_q       <= 1'b1;
            after_step_q <= 1'b0;
          end
        end
        READ: begin
          shadow_q <= bus.pc_addr;
          if (after_step_q && (bus.pc_addr != shadow_next)) begin
            seq_err_q <= 1'b1;
          end
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_zero) begin
            instr_data_q  <= bus.mem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
`ifdef FETCH_WRAP_STOP_EN
            if (shadow_q == '1) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= STEP;
              pc_incr_q <= 1'b1;
            end
`else
            state_q   <= STEP;
            pc_incr_q <= 1'b1;
`endif
          end
        end
        STEP: begin
          state_q      <= READ;
          rd_en_q      <= 1'b1;
          after_step_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The PC only settles at the STEP->READ edge, so the address follows pc_addr during the strobe.
  assign bus.mem_addr    = rd_en_q ? bus.pc_addr : '0;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.pc_incr     = pc_incr_q;
  assign bus.instr_data  = instr_data_q;
  assign bus.instr_valid = instr_valid_q;
  assign busy_o          = busy_q;
  assign seq_err_o       = seq_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench: PC-counter and ROM models around two sequencers (read latency 1 and 3).
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic busy_a, seq_err_a, busy_b, seq_err_b;

  logic [15:0] rom [256];
  logic [7:0]  pc_a = 8'h00;
  logic [7:0]  pc_b = 8'h42;
  logic [7:0]  pc_ld_val = 8'h00;
  logic        pc_ld = 1'b0;
  logic        incr_prev_a = 1'b0;
  logic        hold_req = 1'b0, hold_done = 1'b0;
  logic [15:0] rd_a = '0, p1_b = '0, p2_b = '0, rd_b = '0;

  int errors = 0;
  int checks = 0;
  logic [15:0] words[$];
  int          incr_cyc[$];
  int          first_valid;
  int          width_err;

  pc_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifa ();
  pc_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ifb ();

  pc_fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start_i(start_a),
    .busy_o(busy_a), .seq_err_o(seq_err_a), .bus(ifa.master)
  );

  pc_fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b),
    .busy_o(busy_b), .seq_err_o(seq_err_b), .bus(ifb.master)
  );

  always #5 clk = ~clk;

  assign ifa.pc_addr     = pc_a;
  assign ifa.mem_rdata   = rd_a;
  assign ifa.instr_ready = ready_a;
  assign ifb.pc_addr     = pc_b;
  assign ifb.mem_rdata   = rd_b;
  assign ifb.instr_ready = ready_b;

  // PC counter: advances on rising edges of incr; hold_req swallows exactly one pulse.
  always @(posedge clk) begin
    incr_prev_a <= ifa.pc_incr;
    if (pc_ld) pc_a <= pc_ld_val;
    else if (ifa.pc_incr && !incr_prev_a) begin
      if (hold_req && !hold_done) hold_done <= 1'b1;
      else pc_a <= pc_a + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (ifa.mem_rd_en) rd_a <= rom[ifa.mem_addr];
  end

  always @(posedge clk) begin
    if (ifb.mem_rd_en) p1_b <= rom[ifb.mem_addr];
    p2_b <= p1_b;
    rd_b <= p2_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pc_a(input logic [7:0] v);
    pc_ld_val = v;
    pc_ld = 1'b1;
    @(negedge clk);
    pc_ld = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid_a(input string tag, input int lim);
    int k;
    k = 0;
    while (!ifa.instr_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(ifa.instr_valid), 32'd1);
  endtask

  // Cycle 0 is the first negedge after start was sampled.
  task automatic run_a(input string tag, input int nw, input int ni, input int lim);
    int   cyc;
    logic prev;
    cyc = 0;
    prev = 1'b0;
    first_valid = -1;
    width_err = 0;
    words.delete();
    incr_cyc.delete();
    while ((words.size() < nw || incr_cyc.size() < ni) && cyc < lim) begin
      if (ifa.instr_valid && first_valid < 0) first_valid = cyc;
      if (ifa.instr_valid && ready_a) words.push_back(ifa.instr_data);
      if (ifa.pc_incr) begin
        incr_cyc.push_back(cyc);
        if (prev) width_err++;
      end
      prev = ifa.pc_incr;
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(cyc < lim), 32'd1);
  endtask

  initial begin
    int k, chg, inc;
    logic [15:0] d0;

    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'h00A1;
    rom[1] = 16'h00B2;
    rom[2] = 16'h00C3;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ifa.instr_valid), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_incr", 32'(ifa.pc_incr), 32'd0);
    chk("rst_rden", 32'(ifa.mem_rd_en), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: reset while a word is presented
    load_pc_a(8'h05);
    pulse_start_a();
    wait_valid_a("t1_valid", 10);
    chk("t1_data", 32'(ifa.instr_data), 32'h1005);
    chk("t1_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("t1_valid_drop", 32'(ifa.instr_valid), 32'd0);
    chk("t1_incr", 32'(ifa.pc_incr), 32'd0);
    chk("t1_busy_drop", 32'(busy_a), 32'd0);
    chk("t1_seq_err", 32'(seq_err_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // T2: three words from PC 0 with ready tied high
    load_pc_a(8'h00);
    ready_a = 1'b1;
    pulse_start_a();
    run_a("t2_run", 3, 3, 40);
    ready_a = 1'b0;
    chk("t2_w0", 32'(words[0]), 32'h00A1);
    chk("t2_w1", 32'(words[1]), 32'h00B2);
    chk("t2_w2", 32'(words[2]), 32'h00C3);
    chk("t2_first_valid", 32'(first_valid), 32'd2);
    chk("t2_incr0", 32'(incr_cyc[0]), 32'd3);
    chk("t2_gap1", 32'(incr_cyc[1] - incr_cyc[0]), 32'd4);
    chk("t2_gap2", 32'(incr_cyc[2] - incr_cyc[1]), 32'd4);
    chk("t2_width", 32'(width_err), 32'd0);
    chk("t2_pc", 32'(pc_a), 32'h03);

    // T3: backpressure on the word at address 3
    wait_valid_a("t3_valid", 10);
    d0 = ifa.instr_data;
    chk("t3_data", 32'(d0), 32'h1003);
    chg = 0;
    inc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifa.instr_data !== d0) chg++;
      if (ifa.pc_incr) inc++;
    end
    chk("t3_stable", 32'(chg), 32'd0);
    chk("t3_no_incr", 32'(inc), 32'd0);
    chk("t3_still_valid", 32'(ifa.instr_valid), 32'd1);
    chk("t3_pc_hold", 32'(pc_a), 32'h03);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    inc = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifa.pc_incr) inc++;
      @(negedge clk);
    end
    chk("t3_one_pulse", 32'(inc), 32'd1);
    chk("t3_pc_step", 32'(pc_a), 32'h04);

    // T4: read latency 3 on the second instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (!ifb.instr_valid && k < 20) begin
      chk("t4_no_incr", 32'(ifb.pc_incr), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("t4_latency", 32'(k), 32'd4);
    chk("t4_data", 32'(ifb.instr_data), 32'h1042);
    chk("t4_busy", 32'(busy_b), 32'd1);
    chk("t4_seq_err", 32'(seq_err_b), 32'd0);

    // T5: wrap from 0xFE
    do_reset();
    load_pc_a(8'hFE);
    ready_a = 1'b1;
    pulse_start_a();
`ifdef FETCH_WRAP_STOP_EN
    run_a("t5_run", 2, 1, 40);
    for (int i = 0; i < 4; i++) @(negedge clk);
    ready_a = 1'b0;
    chk("t5_w0", 32'(words[0]), 32'h10FE);
    chk("t5_w1", 32'(words[1]), 32'h10FF);
    chk("t5_done_busy", 32'(busy_a), 32'd0);
    chk("t5_done_valid", 32'(ifa.instr_valid), 32'd0);
    chk("t5_pc", 32'(pc_a), 32'hFF);
`else
    run_a("t5_run", 3, 3, 40);
    ready_a = 1'b0;
    chk("t5_w0", 32'(words[0]), 32'h10FE);
    chk("t5_w1", 32'(words[1]), 32'h10FF);
    chk("t5_w2", 32'(words[2]), 32'h00A1);
    chk("t5_pc", 32'(pc_a), 32'h01);
`endif
    chk("t5_seq_err", 32'(seq_err_a), 32'd0);

    // T6: PC ignores the first pulse
    do_reset();
    load_pc_a(8'h10);
    hold_req = 1'b1;
    ready_a = 1'b1;
    pulse_start_a();
    run_a("t6_run", 3, 3, 60);
    chk("t6_w0", 32'(words[0]), 32'h1010);
    chk("t6_w1_refetch", 32'(words[1]), 32'h1010);
    chk("t6_w2", 32'(words[2]), 32'h1011);
    chk("t6_seq_err", 32'(seq_err_a), 32'd1);
    run_a("t6_run2", 1, 1, 40);
    ready_a = 1'b0;
    chk("t6_w3", 32'(words[0]), 32'h1012);
    chk("t6_sticky", 32'(seq_err_a), 32'd1);
    do_reset();
    chk("t6_cleared", 32'(seq_err_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
